// File: rtl/cflog_pkg.sv
// Shared definitions for the CFLog verifier-side blocks.
// Holds the address and counter widths, the expander FSM state enum,
// the smallest legal loop count, and the TCB address constants that the
// checker blocks also use.
package cflog_pkg;

    localparam int unsigned ADDR_W       = 16;
    localparam int unsigned CTR_W        = 32;
    localparam int unsigned LOOP_CTR_MIN = 3;

    localparam logic [15:0] TCB_BASE = 16'hA000;
    localparam logic [15:0] TCB_EXIT = 16'hDFFE;

    typedef enum logic [1:0] {
        IDLE,
        PASS,
        REPLAY,
        LOOPED
    } state_e;

endpackage

// File: rtl/cflog_out_reg.sv
// Valid/ready output register for the expanded edge stream.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   load_i          - capture src_i/dest_i/replay_i (the caller only loads when the slot is free)
//   src_i, dest_i   - edge to present
//   replay_i        - edge is a regenerated loop copy
//   ready_i         - downstream accepts the presented edge
//   valid_o, src_o, dest_o, replay_o - registered output edge
module cflog_out_reg #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] src_i,
    input  logic [ADDR_W-1:0] dest_i,
    input  logic              replay_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] src_o,
    output logic [ADDR_W-1:0] dest_o,
    output logic              replay_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dest_q;
    logic              replay_q;

    // Data is only written on load, so it holds still while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            src_q    <= '0;
            dest_q   <= '0;
            replay_q <= 1'b0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            src_q    <= src_i;
            dest_q   <= dest_i;
            replay_q <= replay_i;
        end else if (ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign src_o    = src_q;
    assign dest_o   = dest_q;
    assign replay_o = replay_q;

endmodule

// File: rtl/cflog_loop_expander.sv
// Expands the loop-compressed CFLog into a plain edge stream by replaying
// the last normal edge C-2 times for each loop-count entry (counter C).
// Ports:
//   clk, rst_n                    - clock, asynchronous active-low reset
//   in_valid/in_ready             - log entry handshake
//   in_src/in_dest                - edge, or counter {hi, lo} when in_loop=1
//   in_loop                       - entry is a loop count
//   out_valid/out_ready           - expanded edge handshake
//   out_src/out_dest/out_replay   - expanded edge, out_replay marks loop copies
//   err                           - sticky malformed-log flag
//   clear                         - synchronous: forget last edge, clear err
// Optional (CFLOG_EXPANDER_STATS_EN defined):
//   stat_edges, stat_loops, stat_max_iter - saturating statistics
module cflog_loop_expander #(
    parameter int unsigned ADDR_W = cflog_pkg::ADDR_W,
    parameter int unsigned CTR_W  = cflog_pkg::CTR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_src,
    input  logic [ADDR_W-1:0] in_dest,
    input  logic              in_loop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_src,
    output logic [ADDR_W-1:0] out_dest,
    output logic              out_replay,
    output logic              err,
    input  logic              clear
`ifdef CFLOG_EXPANDER_STATS_EN
    ,
    output logic [31:0]       stat_edges,
    output logic [15:0]       stat_loops,
    output logic [CTR_W-1:0]  stat_max_iter
`endif
);

    import cflog_pkg::*;

    state_e            state_q, state_d;
    logic [CTR_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] last_src_q, last_src_d;
    logic [ADDR_W-1:0] last_dest_q, last_dest_d;
    logic              last_ok_q, last_ok_d;
    logic              err_q, err_d;
    logic              alive_q;

    logic [CTR_W-1:0]  ctr_c;
    logic              out_free_c;
    logic              in_fire_c;
    logic              ld_c;
    logic              ld_replay_c;
    logic [ADDR_W-1:0] ld_src_c;
    logic [ADDR_W-1:0] ld_dest_c;

    assign ctr_c      = {in_src, in_dest};
    assign out_free_c = !out_valid || out_ready;
    // alive_q keeps in_ready low while reset is held.
    assign in_ready   = alive_q && (state_q != REPLAY) && out_free_c;
    assign in_fire_c  = in_valid && in_ready;

    // Next-state and output-load decode.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        last_src_d  = last_src_q;
        last_dest_d = last_dest_q;
        last_ok_d   = last_ok_q;
        err_d       = err_q;
        ld_c        = 1'b0;
        ld_replay_c = 1'b0;
        ld_src_c    = in_src;
        ld_dest_c   = in_dest;

        if (clear) begin
            state_d   = IDLE;
            rem_d     = '0;
            last_ok_d = 1'b0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_fire_c) begin
                        if (in_loop) begin
                            err_d = 1'b1;
                        end else begin
                            ld_c        = 1'b1;
                            last_src_d  = in_src;
                            last_dest_d = in_dest;
                            last_ok_d   = 1'b1;
                            state_d     = PASS;
                        end
                    end
                end
                PASS, LOOPED: begin
                    if (in_fire_c) begin
                        if (!in_loop) begin
                            ld_c        = 1'b1;
                            last_src_d  = in_src;
                            last_dest_d = in_dest;
                            last_ok_d   = 1'b1;
                            state_d     = PASS;
                        end else if ((state_q == PASS) && last_ok_q &&
                                     (ctr_c >= CTR_W'(LOOP_CTR_MIN))) begin
                            // First copy leaves with the accepting handshake;
                            // rem counts the copies still owed after it.
                            ld_c        = 1'b1;
                            ld_replay_c = 1'b1;
                            ld_src_c    = last_src_q;
                            ld_dest_c   = last_dest_q;
                            rem_d       = ctr_c - CTR_W'(LOOP_CTR_MIN);
                            state_d     = (ctr_c == CTR_W'(LOOP_CTR_MIN)) ? LOOPED : REPLAY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                REPLAY: begin
                    if (out_free_c) begin
                        ld_c        = 1'b1;
                        ld_replay_c = 1'b1;
                        ld_src_c    = last_src_q;
                        ld_dest_c   = last_dest_q;
                        rem_d       = rem_q - CTR_W'(1);
                        if (rem_q == CTR_W'(1)) begin
                            state_d = LOOPED;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and last-edge registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            last_src_q  <= '0;
            last_dest_q <= '0;
            last_ok_q   <= 1'b0;
            err_q       <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            last_src_q  <= last_src_d;
            last_dest_q <= last_dest_d;
            last_ok_q   <= last_ok_d;
            err_q       <= err_d;
            alive_q     <= 1'b1;
        end
    end

    assign err = err_q;

    cflog_out_reg #(
        .ADDR_W (ADDR_W)
    ) u_out_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ld_c),
        .src_i    (ld_src_c),
        .dest_i   (ld_dest_c),
        .replay_i (ld_replay_c),
        .ready_i  (out_ready),
        .valid_o  (out_valid),
        .src_o    (out_src),
        .dest_o   (out_dest),
        .replay_o (out_replay)
    );

`ifdef CFLOG_EXPANDER_STATS_EN
    logic [31:0]      st_edges_q;
    logic [15:0]      st_loops_q;
    logic [CTR_W-1:0] st_max_q;
    logic             loop_exp_c;

    assign loop_exp_c = in_fire_c && in_loop && (state_q == PASS) && last_ok_q &&
                        (ctr_c >= CTR_W'(LOOP_CTR_MIN));

    // Saturating statistics, zeroed by clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_edges_q <= '0;
            st_loops_q <= '0;
            st_max_q   <= '0;
        end else if (clear) begin
            st_edges_q <= '0;
            st_loops_q <= '0;
            st_max_q   <= '0;
        end else begin
            if (out_valid && out_ready && (st_edges_q != '1)) begin
                st_edges_q <= st_edges_q + 32'd1;
            end
            if (loop_exp_c && (st_loops_q != '1)) begin
                st_loops_q <= st_loops_q + 16'd1;
            end
            if (in_fire_c && in_loop && (ctr_c > st_max_q)) begin
                st_max_q <= ctr_c;
            end
        end
    end

    assign stat_edges    = st_edges_q;
    assign stat_loops    = st_loops_q;
    assign stat_max_iter = st_max_q;
`endif

endmodule
